serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 152 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one fullAdder is stepped LSB-first over WIDTH RUN cycles.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' input for two's-complement A-B.

module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cIn,
  output logic sum,
  output logic cOut
);

  assign sum  = a ^ b ^ cIn;
  assign cOut = (a & b) | (cIn & (a ^ b));

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             cInit,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cOutFinal
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_regA;
  logic [WIDTH-1:0] r_regB;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_count;
  logic             r_carry;
  logic             r_cOutFinal;
  logic             w_accept;
  logic             w_lastBit;
  logic             w_bIn;
  logic             w_sum;
  logic             w_cOut;

`ifdef SERIAL_ADDER_SUB_EN
  logic             r_sub;

  // Subtraction inverts B bit by bit; the +1 comes from the forced initial carry.
  assign w_bIn = r_regB[0] ^ r_sub;
`else
  assign w_bIn = r_regB[0];
`endif

  assign w_accept  = (r_state == IDLE) && start;
  assign w_lastBit = (r_state == RUN) && (r_count == LAST_COUNT);

  fullAdder u_fullAdder (
    .a    (r_regA[0]),
    .b    (w_bIn),
    .cIn  (r_carry),
    .sum  (w_sum),
    .cOut (w_cOut)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = RUN;
      RUN:     if (w_lastBit) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      RUN: begin
        busy = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Shift-based forms keep WIDTH=1 legal (no reversed part-selects).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regA      <= '0;
      r_regB      <= '0;
      r_result    <= '0;
      r_count     <= '0;
      r_carry     <= 1'b0;
      r_cOutFinal <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      r_sub       <= 1'b0;
`endif
    end else if (w_accept) begin
      r_regA   <= opA;
      r_regB   <= opB;
      r_result <= '0;
      r_count  <= '0;
`ifdef SERIAL_ADDER_SUB_EN
      r_sub    <= sub;
      r_carry  <= sub ? 1'b1 : cInit;
`else
      r_carry  <= cInit;
`endif
    end else if (r_state == RUN) begin
      r_regA   <= r_regA >> 1;
      r_regB   <= r_regB >> 1;
      r_result <= (r_result >> 1) | (WIDTH'(w_sum) << (WIDTH - 1));
      r_carry  <= w_cOut;
      r_count  <= r_count + 1'b1;
      if (w_lastBit) begin
        r_cOutFinal <= w_cOut;
      end
    end
  end

  assign result    = r_result;
  assign cOutFinal = r_cOutFinal;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8); SERIAL_ADDER_SUB_EN enables the subtract scenario.

module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             cInit;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cOutFinal;

  int nChecks;
  int nFails;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .opA       (opA),
    .opB       (opB),
    .cInit     (cInit),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cOutFinal (cOutFinal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one job and waits (bounded) for done; reports what it saw.
  task automatic run_job(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic c, input logic s,
                         output int lat, output int busyCyc,
                         output logic [WIDTH-1:0] res, output logic co);
    opA = a;
    opB = b;
    cInit = c;
`ifdef SERIAL_ADDER_SUB_EN
    sub = s;
`else
    if (s) $display("[TB] note: subtract requested without SERIAL_ADDER_SUB_EN");
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    opA = ~a;
    opB = ~b;
    cInit = ~c;
    lat = 0;
    busyCyc = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busyCyc++;
      tick();
      lat++;
    end
    if (busy === 1'b1) busyCyc++;
    res = result;
    co = cOutFinal;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL reset_done got %b want 0", done); end
    nChecks++; if (result !== 8'h00) begin nFails++; $display("[TB] FAIL reset_result got %h want 00", result); end
    nChecks++; if (cOutFinal !== 1'b0) begin nFails++; $display("[TB] FAIL reset_cout got %b want 0", cOutFinal); end
  endtask

  task automatic test_basic_add();
    int lat, busyCyc;
    logic [WIDTH-1:0] res;
    logic co;
    run_job(8'h5A, 8'h3C, 1'b0, 1'b0, lat, busyCyc, res, co);
    nChecks++; if (lat !== WIDTH) begin nFails++; $display("[TB] FAIL basic_latency got %0d want %0d", lat, WIDTH); end
    nChecks++; if (busyCyc !== WIDTH + 1) begin nFails++; $display("[TB] FAIL basic_busy_cycles got %0d want %0d", busyCyc, WIDTH + 1); end
    nChecks++; if (res !== 8'h96) begin nFails++; $display("[TB] FAIL basic_result got %h want 96", res); end
    nChecks++; if (co !== 1'b0) begin nFails++; $display("[TB] FAIL basic_cout got %b want 0", co); end
    tick();
    nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL basic_done_pulse got %b want 0", done); end
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL basic_idle_busy got %b want 0", busy); end
    tick();
    nChecks++; if (result !== 8'h96) begin nFails++; $display("[TB] FAIL basic_result_hold got %h want 96", result); end
  endtask

  task automatic test_ignore_start();
    int lat, dones;
    opA = 8'h12;
    opB = 8'h34;
    cInit = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    // Third RUN cycle: this request must be dropped.
    opA = 8'hFF;
    opB = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 3;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    nChecks++; if (lat !== WIDTH) begin nFails++; $display("[TB] FAIL ignore_latency got %0d want %0d", lat, WIDTH); end
    nChecks++; if (result !== 8'h46) begin nFails++; $display("[TB] FAIL ignore_result got %h want 46", result); end
    nChecks++; if (cOutFinal !== 1'b0) begin nFails++; $display("[TB] FAIL ignore_cout got %b want 0", cOutFinal); end
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    nChecks++; if (dones !== 0) begin nFails++; $display("[TB] FAIL ignore_second_done got %0d want 0", dones); end
  endtask

  task automatic test_carry();
    int lat, busyCyc;
    logic [WIDTH-1:0] res;
    logic co;
    run_job(8'hFF, 8'h01, 1'b0, 1'b0, lat, busyCyc, res, co);
    nChecks++; if (res !== 8'h00) begin nFails++; $display("[TB] FAIL carry1_result got %h want 00", res); end
    nChecks++; if (co !== 1'b1) begin nFails++; $display("[TB] FAIL carry1_cout got %b want 1", co); end
    tick();
    run_job(8'hFF, 8'h00, 1'b1, 1'b0, lat, busyCyc, res, co);
    nChecks++; if (lat !== WIDTH) begin nFails++; $display("[TB] FAIL carry2_latency got %0d want %0d", lat, WIDTH); end
    nChecks++; if (res !== 8'h00) begin nFails++; $display("[TB] FAIL carry2_result got %h want 00", res); end
    nChecks++; if (co !== 1'b1) begin nFails++; $display("[TB] FAIL carry2_cout got %b want 1", co); end
    tick();
  endtask

  task automatic test_abort();
    int lat, busyCyc, dones;
    logic [WIDTH-1:0] res;
    logic co;
    opA = 8'hAA;
    opB = 8'h55;
    cInit = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
    nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL abort_done got %b want 0", done); end
    nChecks++; if (result !== 8'h00) begin nFails++; $display("[TB] FAIL abort_result got %h want 00", result); end
    nChecks++; if (cOutFinal !== 1'b0) begin nFails++; $display("[TB] FAIL abort_cout got %b want 0", cOutFinal); end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    nChecks++; if (dones !== 0) begin nFails++; $display("[TB] FAIL abort_stray_done got %0d want 0", dones); end
    run_job(8'h01, 8'h01, 1'b0, 1'b0, lat, busyCyc, res, co);
    nChecks++; if (res !== 8'h02) begin nFails++; $display("[TB] FAIL abort_next_result got %h want 02", res); end
    nChecks++; if (co !== 1'b0) begin nFails++; $display("[TB] FAIL abort_next_cout got %b want 0", co); end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc, nDone, lastDone;
    opA = 8'h0F;
    opB = 8'h01;
    cInit = 1'b0;
    start = 1'b1;
    nDone = 0;
    lastDone = -1;
    for (cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (done === 1'b1) begin
        nChecks++; if (result !== 8'h10) begin nFails++; $display("[TB] FAIL b2b_result got %h want 10", result); end
        if (lastDone >= 0) begin
          nChecks++; if (cyc - lastDone !== WIDTH + 2) begin nFails++; $display("[TB] FAIL b2b_spacing got %0d want %0d", cyc - lastDone, WIDTH + 2); end
        end
        lastDone = cyc;
        nDone++;
      end else if (busy === 1'b0 && nDone > 0) begin
        nChecks++; if (result !== 8'h10) begin nFails++; $display("[TB] FAIL b2b_idle_hold got %h want 10", result); end
      end
    end
    start = 1'b0;
    nChecks++; if (nDone < 3) begin nFails++; $display("[TB] FAIL b2b_job_count got %0d want >=3", nDone); end
    for (int i = 0; i < 12; i++) tick();
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_subtract();
    int lat, busyCyc;
    logic [WIDTH-1:0] res;
    logic co;
    run_job(8'h10, 8'h01, 1'b0, 1'b1, lat, busyCyc, res, co);
    nChecks++; if (res !== 8'h0F) begin nFails++; $display("[TB] FAIL sub1_result got %h want 0f", res); end
    nChecks++; if (co !== 1'b1) begin nFails++; $display("[TB] FAIL sub1_cout got %b want 1", co); end
    tick();
    run_job(8'h01, 8'h02, 1'b0, 1'b1, lat, busyCyc, res, co);
    nChecks++; if (res !== 8'hFF) begin nFails++; $display("[TB] FAIL sub2_result got %h want ff", res); end
    nChecks++; if (co !== 1'b0) begin nFails++; $display("[TB] FAIL sub2_cout got %b want 0", co); end
    tick();
    sub = 1'b0;
  endtask
`endif

  initial begin
    nChecks = 0;
    nFails = 0;
    rst = 1'b1;
    start = 1'b0;
    opA = '0;
    opB = '0;
    cInit = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    test_reset();
    test_basic_add();
    test_ignore_start();
    test_carry();
    test_abort();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_subtract();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
